// File: rtl/pio_edge_irq_ctrl_pkg.sv
// Shared constants for the edge-capturing PIO: register map, edge-type
// encodings and controller state.
package pio_edge_irq_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

endpackage

// File: rtl/pio_edge_irq_ctrl_debounce.sv
// One input pin: 2-flop synchronizer followed by a stable-count debouncer.
// While bypass is high the debounced value tracks the synchronizer directly.
module pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bypass,
  input  logic pin_async,
  output logic sync_o,
  output logic deb_o
);

  localparam logic [7:0] CNT_TC = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       deb_q, deb_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = pin_async;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (bypass) begin
      deb_d = sync2_q;
    end else if (sync2_q != deb_q) begin
      // Counter reaching the threshold commits the new level and restarts.
      if ((cnt_q + 8'd1) == CNT_TC) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o = sync2_q;
  assign deb_o  = deb_q;

endmodule

// File: rtl/pio_edge_irq_ctrl.sv
// Avalon-MM input PIO with debounced pins, sticky edge capture (W1C) and a
// maskable level interrupt. Read data is registered one cycle behind address.
module pio_edge_irq_ctrl
  import pio_edge_irq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [8:0] WARM_TC = 9'(DEBOUNCE_CYCLES + 1);

  state_e           state_q, state_d;
  logic [8:0]       wcnt_q, wcnt_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] deb_w;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] w1c;
  logic             warm;
  logic             wr_en;
  logic             unused_wdata;

  assign warm         = (state_q == ST_WARMUP);
  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .bypass   (warm),
      .pin_async(in_port[g]),
      .sync_o   (sync_w[g]),
      .deb_o    (deb_w[g])
    );
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WARMUP: begin
        if (wcnt_q == WARM_TC) begin
          state_d = ST_RUN;
        end else begin
          wcnt_d = wcnt_q + 9'd1;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_WARMUP;
    endcase
  end

  always_comb begin
    edge_det = '0;
    if (!warm) begin
      if (EDGE_TYPE == EDGE_RISING) begin
        edge_det = deb_w & ~prev_q;
      end else if (EDGE_TYPE == EDGE_FALLING) begin
        edge_det = ~deb_w & prev_q;
      end else begin
        edge_det = deb_w ^ prev_q;
      end
    end
  end

  always_comb begin
    // During warmup the previous copy follows the synchronizer too, so the
    // first RUN cycle never sees a stale prev and reports a phantom edge.
    prev_d    = warm ? sync_w : deb_w;
    irqmask_d = irqmask_q;
    w1c       = '0;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGECAP)) begin
      w1c = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~w1c) | edge_det;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = deb_w;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_WARMUP;
      wcnt_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      prev_q     <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      prev_q     <= prev_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_edge_irq_ctrl.sv
// Directed bench for pio_edge_irq_ctrl: WIDTH=2, DEBOUNCE_CYCLES=4, rising edges.
module tb_pio_edge_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks;
  int errors;

  pio_edge_irq_ctrl #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    in_port = 2'b01;
    reset_n = 1'b0;
    address = 2'd0;
    wait_n(3);
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset_n = 1'b1;
    // Warmup bypass: DATA visible after 4 edges rather than the 7 a debounced path needs.
    wait_n(4);
    checks++; if (readdata !== 32'd1) begin errors++; $display("FAIL warmup_data: got %h want %h", readdata, 32'd1); end
    wait_n(8);
    bus_read(2'd3, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL warmup_edgecap: got %h want %h", r, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL warmup_irq: got %b want 0", irq); end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, r);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL irqmask_width: got %h want %h", r, 32'd3); end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rsvd_read: got %h want %h", r, 32'd0); end
    bus_write(2'd0, 32'h0000_0002);
    bus_read(2'd0, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL data_ro: got %h want %h", r, 32'd1); end
    bus_write(2'd2, 32'd1);
    bus_read(2'd2, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL irqmask_write: got %h want %h", r, 32'd1); end
  endtask

  task automatic test_rising_edge();
    logic [31:0] r;
    in_port = 2'b00;
    wait_n(10);
    bus_read(2'd3, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL falling_ignored: got %h want %h", r, 32'd0); end
    address = 2'd0;
    in_port = 2'b01;
    wait_n(6);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early: got %b want 0", irq); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL rise_data_early: got %h want %h", readdata, 32'd0); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b want 1", irq); end
    checks++; if (readdata !== 32'd1) begin errors++; $display("FAIL rise_data: got %h want %h", readdata, 32'd1); end
    bus_read(2'd3, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL rise_edgecap: got %h want %h", r, 32'd1); end
  endtask

  task automatic test_w1c();
    logic [31:0] r;
    bus_write(2'd3, 32'd1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq); end
    bus_read(2'd3, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL w1c_edgecap: got %h want %h", r, 32'd0); end
    in_port = 2'b00; wait_n(10);
    in_port = 2'b01; wait_n(10);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL recapture_irq: got %b want 1", irq); end
    in_port = 2'b00; wait_n(10);
    in_port = 2'b01; wait_n(6);
    bus_write(2'd3, 32'd1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b want 1", irq); end
    bus_read(2'd3, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL collide_edgecap: got %h want %h", r, 32'd1); end
    bus_write(2'd3, 32'd1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL collide_clear: got %b want 0", irq); end
  endtask

  task automatic test_mask();
    logic [31:0] r;
    bus_write(2'd2, 32'd0);
    in_port = 2'b00; wait_n(10);
    in_port = 2'b01; wait_n(10);
    bus_read(2'd3, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL masked_edgecap: got %h want %h", r, 32'd1); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b want 0", irq); end
    bus_write(2'd2, 32'd1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b want 1", irq); end
    bus_write(2'd2, 32'd2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL other_bit_mask: got %b want 0", irq); end
    bus_write(2'd2, 32'd1);
  endtask

  task automatic test_glitch();
    logic [31:0] r;
    bus_write(2'd3, 32'd3);
    in_port = 2'b00; wait_n(10);
    in_port = 2'b01; wait_n(3);
    in_port = 2'b00; wait_n(10);
    bus_read(2'd0, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL glitch_data: got %h want %h", r, 32'd0); end
    bus_read(2'd3, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL glitch_edgecap: got %h want %h", r, 32'd0); end
    in_port = 2'b01; wait_n(4);
    in_port = 2'b00; wait_n(12);
    bus_read(2'd3, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL pulse4_edgecap: got %h want %h", r, 32'd1); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pulse4_irq: got %b want 1", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    in_port = 2'b01;
    wait_n(4);
    reset_n = 1'b0;
    address = 2'd0;
    tick();
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL midrst_readdata: got %h want %h", readdata, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b want 0", irq); end
    reset_n = 1'b1;
    wait_n(4);
    checks++; if (readdata !== 32'd1) begin errors++; $display("FAIL midrst_warmup_data: got %h want %h", readdata, 32'd1); end
    wait_n(8);
    bus_read(2'd3, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL midrst_edgecap: got %h want %h", r, 32'd0); end
    bus_read(2'd2, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL midrst_irqmask: got %h want %h", r, 32'd0); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 2'b00;
    test_reset();
    test_regs();
    test_rising_edge();
    test_w1c();
    test_mask();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_edge_irq_ctrl.md
# pio_edge_irq_ctrl

Avalon-MM slave controller for camera-side single-purpose input pins (frame-valid, shutter-done and similar). It synchronizes and debounces `in_port`, detects configured edges into a sticky edge-capture register, and raises a maskable interrupt to the Nios II. It replaces the plain input PIO wherever software needs event notification instead of polling, and keeps the same one-cycle registered read path.

## Interface
Parameters:
- `WIDTH`, 1: number of input pins, 1..32.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before the debounced value changes, 1..255.
- `EDGE_TYPE`, 0: 0 = rising, 1 = falling, 2 = any edge.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  reset, synchronous, active-low.
- `address`  in  2  register word address.
- `chipselect`  in  1  slave select; qualifies writes.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous external pins.
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt to the processor.

## Operation
- Register map:
  - 0 = DATA (RO): debounced pin values, zero-extended.
  - 1 = reserved: reads 0, writes ignored.
  - 2 = IRQMASK (RW): low WIDTH bits.
  - 3 = EDGECAP (W1C): a 1 in a writedata bit clears that bit.
- A write occurs when `chipselect`=1 and `write_n`=0. Bits above WIDTH are ignored on write and read as 0.
- Per-bit path: 2-flop synchronizer, then debouncer.
  - When the synchronized value differs from the debounced value, a counter increments.
  - When it reaches DEBOUNCE_CYCLES, the debounced value takes the new level and the counter clears.
  - Any cycle where the synchronized value equals the debounced value clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Edge detection compares the debounced value with its previous-cycle copy and applies EDGE_TYPE. A detected edge sets the EDGECAP bit, which is sticky until cleared.
- An edge set and a W1C clear of the same bit in the same cycle: the set wins, and the bit stays 1.
- `irq` = OR over all bits of (EDGECAP & IRQMASK), driven combinationally from registers.
- Reads have no side effects.
- FSM with two states:
  - WARMUP, entered on reset: lasts 2+DEBOUNCE_CYCLES cycles. The debounced value loads the synchronized value directly every cycle and edge capture is suppressed, so a pin already high at reset produces no spurious edge. Register writes are accepted. Exit to RUN when the warmup counter reaches terminal count.
  - RUN: normal operation; stays until reset.

## Timing
- Reset values: `readdata`=0, `irq`=0, IRQMASK=0, EDGECAP=0, synchronizers, debounced values and counters = 0, state = WARMUP.
- Reset sampled low on any edge aborts operation: all state returns to reset values on that edge, including mid-debounce and mid-warmup.
- `readdata` is registered and updates every cycle from `address`. Data for the address presented at edge t appears after edge t. A write to IRQMASK at edge t is visible in a read addressed at edge t+1.
- In RUN, for a pin change sampled at edge t:
  - the debounced value changes at edge t+1+DEBOUNCE_CYCLES;
  - EDGECAP sets at the following edge;
  - `irq` asserts in that same cycle if the bit is masked in.
- A W1C write at edge t clears the bit and deasserts `irq` after edge t, unless a new edge sets the bit on that same edge.

## Structure
- A shared package holds the register address constants (DATA, RSVD, IRQMASK, EDGECAP), the EDGE_TYPE encodings, and the FSM state enum.
- Sub-module `pio_debounce`: per-bit synchronizer, counter and debounced output, with a warmup-bypass input. It is instantiated WIDTH times with a generate loop.
- The top level holds the register file, edge logic, FSM and read mux.

## Test plan
- Reset with `in_port`=1 held through warmup: EDGECAP stays 0, `irq` stays 0, and DATA reads 1 after warmup.
- RUN, EDGE_TYPE=0, DEBOUNCE_CYCLES=4, IRQMASK=1, rising edge on `in_port`: EDGECAP bit 0 sets 6 edges after sampling, and `irq`=1 on that same cycle.
- 3-cycle glitch with DEBOUNCE_CYCLES=4: DATA is unchanged and EDGECAP stays 0.
- EDGECAP=1, write 0x1 to address 3: `irq` drops the next cycle. Repeat with an edge landing on the clear cycle: bit remains 1.
- IRQMASK=0 with an edge captured: EDGECAP=1 and `irq`=0. Write IRQMASK=1: `irq` asserts the next cycle.
- Assert `reset_n`=0 mid-debounce (counter at 2): all outputs read 0 after the edge, and the FSM restarts WARMUP.
